gpu_warp_register_file: RTL and testbench

Multi-context, multi-read-port register file for the GPU shader core. It holds one NUM_REGS-deep register set per hardware thread context. It provides NUM_RD_PORTS registered read ports with write-to-read forwarding and a hardwired-zero R0. A sequenced per-context clear engine lets the scheduler recycle a thread slot without a global reset. It sits between the issue stage (reads) and the writeback stage (single write port).

---
 rtl/gpu_rf_pkg.sv | 15 +
 rtl/gpu_rf_clear_seq.sv | 78 +++++++
 rtl/gpu_warp_register_file.sv | 118 +++++++++++
 tb/tb_gpu_warp_register_file.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_rf_pkg.sv
// Shared types and width helpers for the warp register file.
// The clear sequencer and the storage/read-port top both import this package.
package gpu_rf_pkg;

    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

    function automatic int unsigned rf_addr_width(input int unsigned num_regs);
        return $clog2(num_regs);
    endfunction

    function automatic int unsigned rf_tid_width(input int unsigned num_threads);
        return (num_threads > 1) ? $clog2(num_threads) : 1;
    endfunction

endpackage

// File: rtl/gpu_rf_clear_seq.sv
// Per-context clear sequencer: walks R1..R(NUM_REGS-1) of one latched context,
// one register per cycle, then pulses done.
module gpu_rf_clear_seq
    import gpu_rf_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned ADDR_WIDTH = rf_addr_width(NUM_REGS),
    parameter int unsigned TID_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr_req,
    input  logic [TID_WIDTH-1:0]  i_clr_tid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TID_WIDTH-1:0]  o_tid,
    output logic [ADDR_WIDTH-1:0] o_idx
);

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_REGS - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [TID_WIDTH-1:0]  tid_q, tid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tid_d   = tid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            CLR_IDLE: begin
                // R0 is hardwired, so the sweep starts at R1.
                if (i_clr_req) begin
                    state_d = CLR_RUN;
                    idx_d   = ADDR_WIDTH'(1);
                    tid_d   = i_clr_tid;
                    busy_d  = 1'b1;
                end
            end
            CLR_RUN: begin
                if (idx_q == LastIdx) begin
                    state_d = CLR_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            tid_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tid_q   <= tid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_tid  = tid_q;
    assign o_idx  = idx_q;

endmodule

// File: rtl/gpu_warp_register_file.sv
// Multi-context register file with registered, forwarding read ports, hardwired R0
// and a sequenced per-context clear engine.
module gpu_warp_register_file
    import gpu_rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned NUM_THREADS  = 4,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned ADDR_WIDTH   = rf_addr_width(NUM_REGS),
    parameter int unsigned TID_WIDTH    = rf_tid_width(NUM_THREADS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_wr_en,
    input  logic [TID_WIDTH-1:0]               i_wr_tid,
    input  logic [ADDR_WIDTH-1:0]              i_wr_addr,
    input  logic [DATA_WIDTH-1:0]              i_wr_data,
    input  logic [NUM_RD_PORTS-1:0]            i_rd_en,
    input  logic [NUM_RD_PORTS*TID_WIDTH-1:0]  i_rd_tid,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_RD_PORTS-1:0]            o_rd_valid,
    input  logic                               i_clr_req,
    input  logic [TID_WIDTH-1:0]               i_clr_tid,
    output logic                               o_clr_busy,
    output logic                               o_clr_done
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_THREADS][NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_THREADS][NUM_REGS];

    logic [DATA_WIDTH-1:0] rd_data_q [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0] rd_data_d [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] rd_valid_q, rd_valid_d;

    logic [TID_WIDTH-1:0]  rd_tid  [NUM_RD_PORTS];
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_RD_PORTS];

    logic                  clr_busy;
    logic                  clr_done;
    logic [TID_WIDTH-1:0]  clr_tid;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic                  wr_accept;

    gpu_rf_clear_seq #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TID_WIDTH  (TID_WIDTH)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr_req (i_clr_req),
        .i_clr_tid (i_clr_tid),
        .o_busy    (clr_busy),
        .o_done    (clr_done),
        .o_tid     (clr_tid),
        .o_idx     (clr_idx)
    );

    // Writes into the context being swept are dropped so the sweep cannot be undone.
    assign wr_accept = i_wr_en && (i_wr_addr != '0) && !(clr_busy && (i_wr_tid == clr_tid));

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        assign rd_tid[p]  = i_rd_tid[p*TID_WIDTH +: TID_WIDTH];
        assign rd_addr[p] = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[p];
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_accept) begin
            mem_d[i_wr_tid][i_wr_addr] = i_wr_data;
        end
        if (clr_busy) begin
            mem_d[clr_tid][clr_idx] = '0;
        end
    end

    always_comb begin
        rd_valid_d = i_rd_en;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data_d[p] = rd_data_q[p];
            if (i_rd_en[p]) begin
                if ((clr_busy && (rd_tid[p] == clr_tid)) || (rd_addr[p] == '0)) begin
                    rd_data_d[p] = '0;
                end else if (wr_accept && (i_wr_tid == rd_tid[p]) && (i_wr_addr == rd_addr[p])) begin
                    rd_data_d[p] = i_wr_data;
                end else begin
                    rd_data_d[p] = mem_q[rd_tid[p]][rd_addr[p]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    mem_q[t][r] <= '0;
                end
            end
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                rd_data_q[p] <= '0;
            end
            rd_valid_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_clr_busy = clr_busy;
    assign o_clr_done = clr_done;

endmodule

// File: tb/tb_gpu_warp_register_file.sv
// Self-checking bench for gpu_warp_register_file: directed scenarios followed by
// randomized traffic, all checked against a context-level reference model.
module tb_gpu_warp_register_file;

    localparam int NP = 2;
    localparam int NR = 16;
    localparam int NT = 4;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int TW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_wr_en;
    logic [TW-1:0]    i_wr_tid;
    logic [AW-1:0]    i_wr_addr;
    logic [DW-1:0]    i_wr_data;
    logic [NP-1:0]    i_rd_en;
    logic [NP*TW-1:0] i_rd_tid;
    logic [NP*AW-1:0] i_rd_addr;
    logic [NP*DW-1:0] o_rd_data;
    logic [NP-1:0]    o_rd_valid;
    logic             i_clr_req;
    logic [TW-1:0]    i_clr_tid;
    logic             o_clr_busy;
    logic             o_clr_done;

    gpu_warp_register_file #(
        .DATA_WIDTH   (DW),
        .NUM_REGS     (NR),
        .NUM_THREADS  (NT),
        .NUM_RD_PORTS (NP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_tid   (i_wr_tid),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (i_rd_en),
        .i_rd_tid   (i_rd_tid),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .i_clr_req  (i_clr_req),
        .i_clr_tid  (i_clr_tid),
        .o_clr_busy (o_clr_busy),
        .o_clr_done (o_clr_done)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents plus remaining busy cycles.
    logic [DW-1:0] m_reg [NT][NR];
    int            m_busy;
    logic [TW-1:0] m_clr_tid;
    logic [DW-1:0] e_data [NP];
    logic [NP-1:0] e_valid;
    logic          e_done;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_wr_en   = 1'b0;
        i_wr_tid  = '0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_rd_en   = '0;
        i_rd_tid  = '0;
        i_rd_addr = '0;
        i_clr_req = 1'b0;
        i_clr_tid = '0;
    endtask

    task automatic set_wr(input int tid, input int addr, input logic [DW-1:0] data);
        i_wr_en   = 1'b1;
        i_wr_tid  = TW'(tid);
        i_wr_addr = AW'(addr);
        i_wr_data = data;
    endtask

    task automatic set_rd(input int p, input int tid, input int addr);
        i_rd_en[p]              = 1'b1;
        i_rd_tid[p*TW +: TW]    = TW'(tid);
        i_rd_addr[p*AW +: AW]   = AW'(addr);
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic          cur_busy;
        logic          wr_ok;
        logic [TW-1:0] t;
        logic [AW-1:0] a;
        cur_busy = (m_busy > 0);
        if (!rst_n) begin
            for (int i = 0; i < NT; i++)
                for (int j = 0; j < NR; j++) m_reg[i][j] = '0;
            for (int p = 0; p < NP; p++) e_data[p] = '0;
            m_busy  = 0;
            e_valid = '0;
            e_done  = 1'b0;
            return;
        end
        wr_ok = i_wr_en && (i_wr_addr != 0) && !(cur_busy && i_wr_tid == m_clr_tid);
        for (int p = 0; p < NP; p++) begin
            t = i_rd_tid[p*TW +: TW];
            a = i_rd_addr[p*AW +: AW];
            e_valid[p] = i_rd_en[p];
            if (i_rd_en[p]) begin
                if ((cur_busy && t == m_clr_tid) || a == 0) e_data[p] = '0;
                else if (wr_ok && t == i_wr_tid && a == i_wr_addr) e_data[p] = i_wr_data;
                else e_data[p] = m_reg[t][a];
            end
        end
        if (wr_ok) m_reg[i_wr_tid][i_wr_addr] = i_wr_data;
        e_done = (m_busy == 1);
        // A cleared context is observably all-zero from acceptance onward.
        if (!cur_busy && i_clr_req) begin
            m_busy    = NR - 1;
            m_clr_tid = i_clr_tid;
            for (int j = 0; j < NR; j++) m_reg[i_clr_tid][j] = '0;
        end else if (m_busy > 0) begin
            m_busy--;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rd_data[%0d]", p), o_rd_data[p*DW +: DW], e_data[p]);
            chk($sformatf("rd_valid[%0d]", p), DW'(o_rd_valid[p]), DW'(e_valid[p]));
        end
        chk("clr_busy", DW'(o_clr_busy), DW'(m_busy > 0));
        chk("clr_done", DW'(o_clr_done), DW'(e_done));
    endtask

    task automatic read_all();
        for (int t = 0; t < NT; t++) begin
            for (int r = 0; r < NR; r += 2) begin
                idle();
                set_rd(0, t, r);
                set_rd(1, t, r + 1);
                tick();
            end
        end
    endtask

    int busy_cycles;
    int done_at;

    initial begin
        idle();
        m_busy = 0;
        m_clr_tid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Write then read on the following cycle.
        idle(); set_wr(2, 5, 32'hDEADBEEF); tick();
        idle(); set_rd(0, 2, 5); tick();
        chk("wr_then_rd", o_rd_data[DW-1:0], 32'hDEADBEEF);
        chk("wr_then_rd_valid", DW'(o_rd_valid[0]), 32'h1);

        // Same-cycle forwarding to both ports.
        idle(); set_wr(1, 3, 32'h1234); set_rd(0, 1, 3); set_rd(1, 1, 3); tick();
        chk("fwd_p0", o_rd_data[DW-1:0], 32'h1234);
        chk("fwd_p1", o_rd_data[2*DW-1:DW], 32'h1234);

        // R0 discards writes.
        idle(); set_wr(0, 0, 32'hFFFFFFFF); tick();
        idle(); set_rd(0, 0, 0); tick();
        chk("r0_zero", o_rd_data[DW-1:0], 32'h0);

        // Fill contexts 0 and 1, then clear context 1.
        for (int t = 0; t < 2; t++)
            for (int r = 1; r < NR; r++) begin
                idle(); set_wr(t, r, $urandom | 32'h1); tick();
            end
        idle(); i_clr_req = 1'b1; i_clr_tid = 2'd1; set_wr(1, 9, 32'h5A5A); tick();
        busy_cycles = o_clr_busy ? 1 : 0;
        done_at = -1;
        for (int c = 2; c <= 20; c++) begin
            idle();
            if (c == 5) set_wr(1, 7, 32'hAAAA);
            if (c == 6) set_rd(1, 1, 7);
            if (c == 7) set_rd(0, 0, 7);
            tick();
            if (c == 6) chk("midclr_rd_zero", o_rd_data[2*DW-1:DW], 32'h0);
            if (o_clr_busy) busy_cycles++;
            if (o_clr_done && done_at < 0) done_at = c;
        end
        chk("busy_cycles", DW'(busy_cycles), 32'd15);
        chk("done_cycle", DW'(done_at), 32'd16);
        read_all();
        idle(); set_rd(0, 1, 7); set_rd(1, 1, 9); tick();
        chk("cleared_r7", o_rd_data[DW-1:0], 32'h0);
        chk("cleared_r9", o_rd_data[2*DW-1:DW], 32'h0);

        // Request during busy is ignored; request in the done cycle is accepted.
        idle(); i_clr_req = 1'b1; i_clr_tid = 2'd2; tick();
        done_at = -1;
        for (int c = 2; c <= 40 && done_at < 0; c++) begin
            idle();
            if (c == 5) begin i_clr_req = 1'b1; i_clr_tid = 2'd3; end
            tick();
            if (o_clr_done) done_at = c;
        end
        chk("ignored_req_done", DW'(done_at), 32'd16);
        idle(); i_clr_req = 1'b1; i_clr_tid = 2'd0; tick();
        chk("b2b_busy", DW'(o_clr_busy), 32'h1);

        // Reset mid-clear aborts without a done pulse.
        for (int c = 0; c < 4; c++) begin idle(); tick(); end
        idle(); rst_n = 1'b0; tick();
        chk("rst_busy", DW'(o_clr_busy), 32'h0);
        chk("rst_valid", DW'(o_rd_valid), 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            idle(); tick();
            chk("rst_no_done", DW'(o_clr_done), 32'h0);
        end
        read_all();

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            idle();
            if ($urandom_range(0, 1) == 1) set_wr($urandom_range(0, NT-1), $urandom_range(0, NR-1), $urandom);
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 3) != 0) set_rd(p, $urandom_range(0, NT-1), $urandom_range(0, NR-1));
            if ($urandom_range(0, 29) == 0) begin
                i_clr_req = 1'b1;
                i_clr_tid = TW'($urandom_range(0, NT-1));
            end
            tick();
        end
        for (int c = 0; c < NR; c++) begin idle(); tick(); end
        read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
